// File: rtl/uart_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_irq_ctrl
// Brief    : UART interrupt controller. It provides per-source enable,
//            edge/level pending latches with clear strobes, a fixed-priority
//            IIR-style identifier, clear-on-IIR-read and a hold-off FSM that
//            keeps int_o low for a minimum time between assertions.
// Revision : 1.0 - initial release
// ============================================================================
module uart_irq_ctrl #(
    parameter int                   NUM_SRC     = 5,
    parameter int                   ID_W        = 3,
    parameter int                   HOLDOFF_W   = 8,
    parameter logic [NUM_SRC-1:0]   RD_CLR_MASK = 5'b01000
) (
    input  logic                    clk,
    input  logic                    wb_rst_i,
    input  logic [NUM_SRC-1:0]      int_src_i,
    input  logic [NUM_SRC-1:0]      int_en_i,
    input  logic [NUM_SRC-1:0]      edge_mode_i,
    input  logic [NUM_SRC-1:0]      clr_i,
    input  logic                    iir_rd_i,
    input  logic [HOLDOFF_W-1:0]    holdoff_i,
    output logic                    int_o,
    output logic [ID_W-1:0]         int_id_o,
    output logic                    int_none_o,
    output logic [NUM_SRC-1:0]      int_pend_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [HOLDOFF_W-1:0]   r_cnt;
    logic                   r_int;
    logic [NUM_SRC-1:0]     r_src_d;
    logic [NUM_SRC-1:0]     r_pend;
    logic [ID_W-1:0]        r_id;
    logic                   r_none;

    logic [NUM_SRC-1:0]     w_rise;
    logic [NUM_SRC-1:0]     w_shown;
    logic [NUM_SRC-1:0]     w_clear;
    logic [NUM_SRC-1:0]     w_pend_nxt;
    logic [ID_W-1:0]        w_id_nxt;

    assign w_rise = int_src_i & ~r_src_d;

    // Next pending value per source: a clear (strobe or IIR read of the
    // identified source) wins over any set in the same cycle.
    always_comb begin
        w_shown    = '0;
        w_clear    = '0;
        w_pend_nxt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_shown[i] = (r_id == ID_W'(i + 1));
            w_clear[i] = clr_i[i] | (iir_rd_i & RD_CLR_MASK[i] & w_shown[i]);
            if (w_clear[i]) begin
                w_pend_nxt[i] = 1'b0;
            end else if (edge_mode_i[i]) begin
                w_pend_nxt[i] = int_en_i[i] & (w_rise[i] | r_pend[i]);
            end else begin
                w_pend_nxt[i] = int_en_i[i] & int_src_i[i];
            end
        end
    end

    // Fixed priority: the lowest pending index wins, reported as index+1.
    always_comb begin
        w_id_nxt = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_id_nxt = ID_W'(i + 1);
            end
        end
    end

    // Source delay line and pending latches.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_src_d <= '0;
            r_pend  <= '0;
        end else begin
            r_src_d <= int_src_i;
            r_pend  <= w_pend_nxt;
        end
    end

    // Registered identifier, one cycle behind the pending vector.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_id   <= '0;
            r_none <= 1'b1;
        end else begin
            r_id   <= w_id_nxt;
            r_none <= ~|r_pend;
        end
    end

    // Hold-off FSM: after int_o drops it stays low for holdoff_i cycles
    // (sampled on entry to HOLD) before IDLE may raise it again.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_int   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|r_pend) begin
                        r_state <= S_ACTIVE;
                        r_int   <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (~|r_pend) begin
                        r_int <= 1'b0;
                        if (holdoff_i == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_HOLD;
                            r_cnt   <= holdoff_i;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_cnt <= HOLDOFF_W'(1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - HOLDOFF_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_int   <= 1'b0;
                end
            endcase
        end
    end

    assign int_o      = r_int;
    assign int_id_o   = r_id;
    assign int_none_o = r_none;
    assign int_pend_o = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_uart_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_irq_ctrl
// Brief    : Directed bench for uart_irq_ctrl with a cycle-level reference
//            model and hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_irq_ctrl;

    localparam int          N    = 5;
    localparam logic [4:0]  MASK = 5'b01000;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [4:0]     src = '0;
    logic [4:0]     en = '0;
    logic [4:0]     emode = '0;
    logic [4:0]     clr = '0;
    logic           rd = 1'b0;
    logic [7:0]     holdoff = '0;
    logic           int_o;
    logic [2:0]     id;
    logic           none;
    logic [4:0]     pend;

    int vectors = 0;
    int miscompares = 0;

    uart_irq_ctrl dut (
        .clk         (clk),
        .wb_rst_i    (rst),
        .int_src_i   (src),
        .int_en_i    (en),
        .edge_mode_i (emode),
        .clr_i       (clr),
        .iir_rd_i    (rd),
        .holdoff_i   (holdoff),
        .int_o       (int_o),
        .int_id_o    (id),
        .int_none_o  (none),
        .int_pend_o  (pend)
    );

    always #5 clk = ~clk;

    // Reference model: pending rules per source, identifier from the previous
    // pending vector, and int_o gated by "cycles since last fall".
    logic [4:0]     m_pend, m_srcd, old_pend, np, rise;
    logic [2:0]     m_id, nid;
    logic           m_none, m_int;
    longint         cyc, fall_cyc;
    int             m_hold;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = '0; m_srcd = '0; m_id = '0; m_none = 1'b1; m_int = 1'b0;
            cyc = 0; fall_cyc = -1000; m_hold = 0;
        end else begin
            cyc      = cyc + 1;
            old_pend = m_pend;
            rise     = src & ~m_srcd;
            for (int i = 0; i < N; i++) begin
                if (clr[i] || (rd && MASK[i] && (int'(m_id) == i + 1)))
                    np[i] = 1'b0;
                else if (emode[i])
                    np[i] = en[i] & (rise[i] | old_pend[i]);
                else
                    np[i] = en[i] & src[i];
            end
            nid = '0;
            for (int i = N - 1; i >= 0; i--)
                if (old_pend[i]) nid = 3'(i + 1);
            if (m_int) begin
                if (old_pend == '0) begin
                    m_int    = 1'b0;
                    fall_cyc = cyc;
                    m_hold   = int'(holdoff);
                end
            end else if (old_pend != '0 && cyc >= fall_cyc + m_hold + 1) begin
                m_int = 1'b1;
            end
            m_id   = nid;
            m_none = (old_pend == '0);
            m_pend = np;
            m_srcd = src;
        end
    end

    // Every-cycle comparison against the model, on the inactive edge.
    always @(negedge clk) begin
        vectors++;
        if (int_o !== m_int || id !== m_id || none !== m_none || pend !== m_pend) begin
            miscompares++;
            $display("FAIL model t=%0t: got int=%b id=%0d none=%b pend=%b, want int=%b id=%0d none=%b pend=%b",
                     $time, int_o, id, none, pend, m_int, m_id, m_none, m_pend);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        en = 5'b11111; emode = 5'b11111; holdoff = 8'd0;
        #20 rst = 1'b0;
        #1;
        chk("reset int", {7'd0, int_o}, 8'd0);
        chk("reset id", {5'd0, id}, 8'd0);
        chk("reset none", {7'd0, none}, 8'd1);
        chk("reset pend", {3'd0, pend}, 8'd0);

        // 1: single edge pulse on source 2, then clear
        src = 5'b00100; tick(); src = '0;
        chk("t1 pend", {3'd0, pend}, 8'h04);
        tick();
        chk("t1 id", {5'd0, id}, 8'd3);
        chk("t1 int", {7'd0, int_o}, 8'd1);
        chk("t1 none", {7'd0, none}, 8'd0);
        tick(); tick();
        clr = 5'b00100; tick(); clr = '0;
        chk("t1 clr pend", {3'd0, pend}, 8'd0);
        tick();
        chk("t1 clr int", {7'd0, int_o}, 8'd0);
        chk("t1 clr id", {5'd0, id}, 8'd0);

        // 2: two sources together, priority and clear of the winner
        src = 5'b10010; tick(); src = '0; tick();
        chk("t2 id", {5'd0, id}, 8'd2);
        clr = 5'b00010; tick(); clr = '0;
        chk("t2 pend", {3'd0, pend}, 8'h10);
        chk("t2 int a", {7'd0, int_o}, 8'd1);
        tick();
        chk("t2 id5", {5'd0, id}, 8'd5);
        chk("t2 int b", {7'd0, int_o}, 8'd1);
        clr = 5'b10000; tick(); clr = '0; tick(); tick();

        // 3: clear-on-read for source 3, no effect on source 0
        src = 5'b01000; tick(); src = '0; tick();
        chk("t3 id4", {5'd0, id}, 8'd4);
        rd = 1'b1; tick(); rd = 1'b0;
        chk("t3 rd pend", {3'd0, pend}, 8'd0);
        tick();
        chk("t3 rd int", {7'd0, int_o}, 8'd0);
        src = 5'b00001; tick(); src = '0; tick();
        chk("t3 id1", {5'd0, id}, 8'd1);
        rd = 1'b1; tick(); rd = 1'b0;
        chk("t3 rd noclr", {3'd0, pend}, 8'h01);
        clr = 5'b00001; tick(); clr = '0; tick(); tick();

        // 4: level mode on source 1
        emode = 5'b11101; src = 5'b00010; tick(); tick();
        chk("t4 level", {3'd0, pend}, 8'h02);
        clr = 5'b00010; tick(); clr = '0;
        chk("t4 clr", {3'd0, pend}, 8'h00);
        tick();
        chk("t4 reset", {3'd0, pend}, 8'h02);
        en = 5'b11101; tick();
        chk("t4 dis", {3'd0, pend}, 8'h00);
        src = '0; en = 5'b11111; emode = 5'b11111; tick(); tick(); tick();

        // 5: hold-off of 4 cycles, new source arrives during hold
        holdoff = 8'd4;
        src = 5'b00001; tick(); src = '0; tick();
        clr = 5'b00001; tick(); clr = '0;
        tick();
        chk("t5 fall", {7'd0, int_o}, 8'd0);
        src = 5'b00100; tick(); src = '0;
        holdoff = 8'd9;
        chk("t5 pend", {3'd0, pend}, 8'h04);
        chk("t5 hold1", {7'd0, int_o}, 8'd0);
        tick(); chk("t5 hold2", {7'd0, int_o}, 8'd0);
        tick(); chk("t5 hold3", {7'd0, int_o}, 8'd0);
        tick(); chk("t5 hold4", {7'd0, int_o}, 8'd0);
        tick();
        chk("t5 reassert", {7'd0, int_o}, 8'd1);
        chk("t5 id3", {5'd0, id}, 8'd3);
        holdoff = 8'd4;

        // 6: clear beats rise, then asynchronous reset mid-HOLD
        src = 5'b10000; clr = 5'b10000; tick(); src = '0; clr = '0;
        chk("t6 clrwin", {3'd0, pend}, 8'h04);
        clr = 5'b00100; tick(); clr = '0; tick();
        src = 5'b01000; tick(); src = '0; tick();
        chk("t6 hold int", {7'd0, int_o}, 8'd0);
        chk("t6 hold none", {7'd0, none}, 8'd0);
        src = 5'b00100;
        #2 rst = 1'b1;
        #1;
        chk("t6 async int", {7'd0, int_o}, 8'd0);
        chk("t6 async none", {7'd0, none}, 8'd1);
        chk("t6 async pend", {3'd0, pend}, 8'd0);
        chk("t6 async id", {5'd0, id}, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6 post rise", {3'd0, pend}, 8'h04);
        src = '0; tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
